// File: rtl/sf1_pkg.sv
// Shared definitions for simple fixed-point unit 1: instruction formats,
// opcodes per format, element widths, decoded-operation record and the
// per-lane arithmetic helper used by the SIMD datapath.
package sf1_pkg;

  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;
  localparam int WORD_BITS = 32;
  localparam int QUAD_BITS = 128;

  typedef enum logic [2:0] {
    FMT_RR   = 3'd0,
    FMT_RI10 = 3'd4,
    FMT_RI16 = 3'd5,
    FMT_RI18 = 3'd6
  } fmt_e;

  // RR opcodes (11 bits)
  localparam logic [10:0] OPC_AH    = 11'b00011001000;
  localparam logic [10:0] OPC_A     = 11'b00011000000;
  localparam logic [10:0] OPC_SFH   = 11'b00001001000;
  localparam logic [10:0] OPC_SF    = 11'b00001000000;
  localparam logic [10:0] OPC_ADDX  = 11'b01101000000;
  localparam logic [10:0] OPC_SFX   = 11'b01101000001;
  localparam logic [10:0] OPC_CG    = 11'b00011000010;
  localparam logic [10:0] OPC_BG    = 11'b00001000010;
  localparam logic [10:0] OPC_AND   = 11'b00011000001;
  localparam logic [10:0] OPC_OR    = 11'b00001000001;
  localparam logic [10:0] OPC_XOR   = 11'b01001000001;
  localparam logic [10:0] OPC_NAND  = 11'b00011001001;
  localparam logic [10:0] OPC_CEQH  = 11'b01111001000;
  localparam logic [10:0] OPC_CEQ   = 11'b01111000000;
  localparam logic [10:0] OPC_CGTH  = 11'b01001001000;
  localparam logic [10:0] OPC_CGT   = 11'b01001000000;
  localparam logic [10:0] OPC_CLGTB = 11'b01011010000;
  localparam logic [10:0] OPC_CLGTH = 11'b01011001000;
  localparam logic [10:0] OPC_CLGT  = 11'b01011000000;

  // RI10 opcodes (8 bits)
  localparam logic [7:0] OPC_AHI    = 8'b00011101;
  localparam logic [7:0] OPC_AI     = 8'b00011100;
  localparam logic [7:0] OPC_SFHI   = 8'b00001101;
  localparam logic [7:0] OPC_SFI    = 8'b00001100;
  localparam logic [7:0] OPC_CEQHI  = 8'b01111101;
  localparam logic [7:0] OPC_CEQI   = 8'b01111100;
  localparam logic [7:0] OPC_CGTHI  = 8'b01001101;
  localparam logic [7:0] OPC_CGTI   = 8'b01001100;
  localparam logic [7:0] OPC_CLGTBI = 8'b01011110;
  localparam logic [7:0] OPC_CLGTHI = 8'b01011101;

  // RI16 opcodes (9 bits)
  localparam logic [8:0] OPC_ILH  = 9'b010000011;
  localparam logic [8:0] OPC_ILHU = 9'b010000010;
  localparam logic [8:0] OPC_IL   = 9'b010000001;
  localparam logic [8:0] OPC_IOHL = 9'b011000001;

  // RI18 opcode (7 bits)
  localparam logic [6:0] OPC_ILA = 7'b0100001;

  typedef enum logic [1:0] {W_BYTE, W_HALF, W_WORD} width_e;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_ADDX, ALU_SFX, ALU_CG, ALU_BG,
    ALU_AND, ALU_OR, ALU_XOR, ALU_NAND, ALU_CEQ, ALU_CGT, ALU_CLGT,
    ALU_LOAD, ALU_IOHL
  } alu_op_e;

  typedef struct packed {
    logic                 valid;
    alu_op_e              op;
    width_e               width;
    logic                 use_imm;
    logic [WORD_BITS-1:0] load_word;
  } decode_t;

  // Operands are left-aligned in 32 bits so byte and halfword lanes reuse
  // the word logic: sums, carries and signed/unsigned orderings of the top
  // bits are unaffected by the zero padding below them.
  function automatic logic [WORD_BITS-1:0] lane_op(alu_op_e op, logic [WORD_BITS-1:0] a,
                                                   logic [WORD_BITS-1:0] b, logic cin);
    logic [WORD_BITS:0]   sum;
    logic [WORD_BITS-1:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = b - a;
      ALU_ADDX: r = a + b + {31'b0, cin};
      ALU_SFX:  r = b + ~a + {31'b0, cin};
      ALU_CG:   r = {31'b0, sum[WORD_BITS]};
      ALU_BG:   r = {31'b0, b >= a};
      ALU_CEQ:  r = {WORD_BITS{a == b}};
      ALU_CGT:  r = {WORD_BITS{$signed(a) > $signed(b)}};
      ALU_CLGT: r = {WORD_BITS{a > b}};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sf1_alu.sv
// Combinational decode and SIMD datapath of simple fixed-point unit 1.
// Vectors here are numbered [127:0] (bit 127 = architectural bit 0, MSB).
// Macro SF1_EXTENDED_ARITH_EN enables addx, sfx, cg and bg.
module sf1_alu
  import sf1_pkg::*;
(
  input  logic [10:0]          op,
  input  logic [2:0]           fmt,
  input  logic [17:0]          imm,
  input  logic [QUAD_BITS-1:0] ra,
  input  logic [QUAD_BITS-1:0] rb,
  input  logic [QUAD_BITS-1:0] rt,
  output logic [QUAD_BITS-1:0] result,
  output logic                 valid
);

  function automatic decode_t dec_op(alu_op_e o, width_e w, logic use_imm);
    return '{valid: 1'b1, op: o, width: w, use_imm: use_imm, load_word: '0};
  endfunction

  function automatic decode_t dec_load(alu_op_e o, logic [WORD_BITS-1:0] lw);
    return '{valid: 1'b1, op: o, width: W_WORD, use_imm: 1'b0, load_word: lw};
  endfunction

  decode_t              dec;
  logic [QUAD_BITS-1:0] opb, res_b, res_h, res_w, res;
  logic [WORD_BITS-1:0] lane;

  // Decode opcode/format pair; anything not listed stays invalid.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dec = '{valid: 1'b0, op: ALU_NONE, width: W_WORD, use_imm: 1'b0, load_word: '0};
    case (fmt)
      FMT_RR: begin
        case (op)
          OPC_AH:    dec = dec_op(ALU_ADD,  W_HALF, 1'b0);
          OPC_A:     dec = dec_op(ALU_ADD,  W_WORD, 1'b0);
          OPC_SFH:   dec = dec_op(ALU_SUB,  W_HALF, 1'b0);
          OPC_SF:    dec = dec_op(ALU_SUB,  W_WORD, 1'b0);
`ifdef SF1_EXTENDED_ARITH_EN
          OPC_ADDX:  dec = dec_op(ALU_ADDX, W_WORD, 1'b0);
          OPC_SFX:   dec = dec_op(ALU_SFX,  W_WORD, 1'b0);
          OPC_CG:    dec = dec_op(ALU_CG,   W_WORD, 1'b0);
          OPC_BG:    dec = dec_op(ALU_BG,   W_WORD, 1'b0);
`endif
          OPC_AND:   dec = dec_op(ALU_AND,  W_WORD, 1'b0);
          OPC_OR:    dec = dec_op(ALU_OR,   W_WORD, 1'b0);
          OPC_XOR:   dec = dec_op(ALU_XOR,  W_WORD, 1'b0);
          OPC_NAND:  dec = dec_op(ALU_NAND, W_WORD, 1'b0);
          OPC_CEQH:  dec = dec_op(ALU_CEQ,  W_HALF, 1'b0);
          OPC_CEQ:   dec = dec_op(ALU_CEQ,  W_WORD, 1'b0);
          OPC_CGTH:  dec = dec_op(ALU_CGT,  W_HALF, 1'b0);
          OPC_CGT:   dec = dec_op(ALU_CGT,  W_WORD, 1'b0);
          OPC_CLGTB: dec = dec_op(ALU_CLGT, W_BYTE, 1'b0);
          OPC_CLGTH: dec = dec_op(ALU_CLGT, W_HALF, 1'b0);
          OPC_CLGT:  dec = dec_op(ALU_CLGT, W_WORD, 1'b0);
          default:   ;
        endcase
      end
      FMT_RI10: begin
        if (op[10:8] == 3'b000) begin
          case (op[7:0])
            OPC_AHI:    dec = dec_op(ALU_ADD,  W_HALF, 1'b1);
            OPC_AI:     dec = dec_op(ALU_ADD,  W_WORD, 1'b1);
            OPC_SFHI:   dec = dec_op(ALU_SUB,  W_HALF, 1'b1);
            OPC_SFI:    dec = dec_op(ALU_SUB,  W_WORD, 1'b1);
            OPC_CEQHI:  dec = dec_op(ALU_CEQ,  W_HALF, 1'b1);
            OPC_CEQI:   dec = dec_op(ALU_CEQ,  W_WORD, 1'b1);
            OPC_CGTHI:  dec = dec_op(ALU_CGT,  W_HALF, 1'b1);
            OPC_CGTI:   dec = dec_op(ALU_CGT,  W_WORD, 1'b1);
            OPC_CLGTBI: dec = dec_op(ALU_CLGT, W_BYTE, 1'b1);
            OPC_CLGTHI: dec = dec_op(ALU_CLGT, W_HALF, 1'b1);
            default:    ;
          endcase
        end
      end
      FMT_RI16: begin
        if (op[10:9] == 2'b00) begin
          case (op[8:0])
            OPC_ILH:  dec = dec_load(ALU_LOAD, {imm[15:0], imm[15:0]});
            OPC_ILHU: dec = dec_load(ALU_LOAD, {imm[15:0], 16'h0000});
            OPC_IL:   dec = dec_load(ALU_LOAD, {{16{imm[15]}}, imm[15:0]});
            OPC_IOHL: dec = dec_load(ALU_IOHL, {16'h0000, imm[15:0]});
            default:  ;
          endcase
        end
      end
      FMT_RI18: begin
        if (op[10:7] == 4'b0000 && op[6:0] == OPC_ILA)
          dec = dec_load(ALU_LOAD, {14'b0, imm});
      end
      default: ;
    endcase
  end

  // Second operand: rb, or the 10-bit immediate replicated at element width.
  always_comb begin
    opb = rb;
    if (dec.use_imm) begin
      case (dec.width)
        W_BYTE:  opb = {16{imm[7:0]}};
        W_HALF:  opb = {8{{{6{imm[9]}}, imm[9:0]}}};
        default: opb = {4{{{22{imm[9]}}, imm[9:0]}}};
      endcase
    end
  end

  // Per-lane arithmetic and compares at each element width.
  always_comb begin
    res_b = '0;
    res_h = '0;
    res_w = '0;
    lane  = '0;
    for (int i = 0; i < QUAD_BITS / BYTE_BITS; i++) begin
      lane = lane_op(dec.op, {ra[BYTE_BITS*i +: BYTE_BITS], 24'b0},
                     {opb[BYTE_BITS*i +: BYTE_BITS], 24'b0}, 1'b0);
      res_b[BYTE_BITS*i +: BYTE_BITS] = lane[31:24];
    end
    for (int i = 0; i < QUAD_BITS / HALF_BITS; i++) begin
      lane = lane_op(dec.op, {ra[HALF_BITS*i +: HALF_BITS], 16'b0},
                     {opb[HALF_BITS*i +: HALF_BITS], 16'b0}, 1'b0);
      res_h[HALF_BITS*i +: HALF_BITS] = lane[31:16];
    end
    for (int i = 0; i < QUAD_BITS / WORD_BITS; i++) begin
      lane = lane_op(dec.op, ra[WORD_BITS*i +: WORD_BITS],
                     opb[WORD_BITS*i +: WORD_BITS], rt[WORD_BITS*i]);
      res_w[WORD_BITS*i +: WORD_BITS] = lane;
    end
  end

  // Final result select; unrecognized instructions produce zero.
  always_comb begin
    case (dec.op)
      ALU_AND:  res = ra & rb;
      ALU_OR:   res = ra | rb;
      ALU_XOR:  res = ra ^ rb;
      ALU_NAND: res = ~(ra & rb);
      ALU_LOAD: res = {4{dec.load_word}};
      ALU_IOHL: res = rt | {4{dec.load_word}};
      ALU_NONE: res = '0;
      default: begin
        case (dec.width)
          W_BYTE:  res = res_b;
          W_HALF:  res = res_h;
          default: res = res_w;
        endcase
      end
    endcase
    result = dec.valid ? res : '0;
    valid  = dec.valid;
  end

endmodule

// File: rtl/simple_fixed_1.sv
// Simple fixed-point unit 1: SIMD add/sub/logical/compare/immediate-load on
// quadwords with a two-stage pipeline to write-back and stage-1 rt export
// for forwarding. Macro SF1_EXTENDED_ARITH_EN enables addx, sfx, cg and bg.
module simple_fixed_1
  import sf1_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic [0:10]  op_code,
  input  logic [2:0]   instr_format,
  input  logic [0:6]   dest_reg_addr,
  input  logic [0:127] src_reg_a,
  input  logic [0:127] src_reg_b,
  input  logic [0:127] store_reg,
  input  logic [0:17]  imm_value,
  input  logic         enable_reg_write,
  input  logic         branch_is_taken,
  output logic [0:127] wb_data,
  output logic [0:6]   wb_reg_addr,
  output logic         wb_enable_reg_write,
  output logic [0:6]   delayed_rt_addr,
  output logic         delayed_enable_reg_write
);

  logic [QUAD_BITS-1:0] alu_result;
  logic                 alu_valid;
  logic [0:127]         s1_data;

  // Whole-vector connections keep bit 0 as the MSB on both sides.
  sf1_alu u_alu (
    .op     (op_code),
    .fmt    (instr_format),
    .imm    (imm_value),
    .ra     (src_reg_a),
    .rb     (src_reg_b),
    .rt     (store_reg),
    .result (alu_result),
    .valid  (alu_valid)
  );

  // Stage 1: capture result and destination; a taken branch squashes the write.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      s1_data                  <= '0;
      delayed_rt_addr          <= '0;
      delayed_enable_reg_write <= 1'b0;
    end else begin
      s1_data                  <= alu_result;
      delayed_rt_addr          <= dest_reg_addr;
      delayed_enable_reg_write <= enable_reg_write & alu_valid & ~branch_is_taken;
    end
  end

  // Stage 2: present the stage-1 instruction to write-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_data             <= '0;
      wb_reg_addr         <= '0;
      wb_enable_reg_write <= 1'b0;
    end else begin
      wb_data             <= s1_data;
      wb_reg_addr         <= delayed_rt_addr;
      wb_enable_reg_write <= delayed_enable_reg_write;
    end
  end

endmodule

// File: tb/tb_simple_fixed_1.sv
// Directed bench for simple_fixed_1: a vector table applied one instruction
// at a time, then hand sequences for branch squash, reset with instructions
// in flight and back-to-back issue.
module tb_simple_fixed_1;

`ifdef SF1_EXTENDED_ARITH_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [0:10]  op_code;
  logic [2:0]   instr_format;
  logic [0:6]   dest_reg_addr;
  logic [0:127] src_reg_a, src_reg_b, store_reg;
  logic [0:17]  imm_value;
  logic         enable_reg_write, branch_is_taken;
  logic [0:127] wb_data;
  logic [0:6]   wb_reg_addr, delayed_rt_addr;
  logic         wb_enable_reg_write, delayed_enable_reg_write;

  int n_checks = 0;
  int n_fail   = 0;

  simple_fixed_1 dut (
    .clock                    (clock),
    .reset                    (reset),
    .op_code                  (op_code),
    .instr_format             (instr_format),
    .dest_reg_addr            (dest_reg_addr),
    .src_reg_a                (src_reg_a),
    .src_reg_b                (src_reg_b),
    .store_reg                (store_reg),
    .imm_value                (imm_value),
    .enable_reg_write         (enable_reg_write),
    .branch_is_taken          (branch_is_taken),
    .wb_data                  (wb_data),
    .wb_reg_addr              (wb_reg_addr),
    .wb_enable_reg_write      (wb_enable_reg_write),
    .delayed_rt_addr          (delayed_rt_addr),
    .delayed_enable_reg_write (delayed_enable_reg_write)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]   fmt;
    logic [10:0]  op;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [127:0] st;
    logic [17:0]  imm;
    logic         en;
    logic [127:0] exp_data;
    logic         exp_we;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [2:0] f, logic [10:0] o, logic [127:0] a, logic [127:0] b,
                              logic [127:0] s, logic [17:0] im, logic en,
                              logic [127:0] d, logic we);
    return '{fmt: f, op: o, ra: a, rb: b, st: s, imm: im, en: en, exp_data: d, exp_we: we};
  endfunction

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [10:0] o, input logic [6:0] rt,
                       input logic [127:0] a, input logic [127:0] b, input logic [127:0] s,
                       input logic [17:0] im, input logic en, input logic br);
    instr_format     = f;
    op_code          = o;
    dest_reg_addr    = rt;
    src_reg_a        = a;
    src_reg_b        = b;
    store_reg        = s;
    imm_value        = im;
    enable_reg_write = en;
    branch_is_taken  = br;
  endtask

  task automatic nop();
    drive(3'd0, 11'd0, 7'd0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  logic [127:0] exp_addx, exp_sfx, exp_cg, exp_bg;

  initial begin
    exp_addx = EXT ? {4{32'd4}} : '0;
    exp_sfx  = EXT ? {4{32'd4}} : '0;
    exp_cg   = EXT ? {4{32'd1}} : '0;
    exp_bg   = EXT ? {4{32'd1}} : '0;

    //            fmt   opcode           ra                    rb                    store_reg            imm        en    expected data          we
    vecs[0]  = mk(3'd0, 11'b00011001000, {8{16'h0010}},        {8{16'h0001}},        '0,                  18'h0,     1'b1, {8{16'h0011}},         1'b1); // ah
    vecs[1]  = mk(3'd4, 11'b00001101,    {8{16'h0005}},        '0,                   '0,                  18'h3FF,   1'b1, {8{16'hFFFA}},         1'b1); // sfhi
    vecs[2]  = mk(3'd4, 11'b01011110,    {16{8'h80}},          '0,                   '0,                  18'h37F,   1'b1, {16{8'hFF}},           1'b1); // clgtbi
    vecs[3]  = mk(3'd5, 11'b010000010,   '0,                   '0,                   '0,                  18'hFFFE,  1'b1, {4{32'hFFFE0000}},     1'b1); // ilhu
    vecs[4]  = mk(3'd6, 11'b0100001,     '0,                   '0,                   '0,                  18'h06666, 1'b1, {4{32'h00006666}},     1'b1); // ila
    vecs[5]  = mk(3'd5, 11'b011000001,   '0,                   '0,                   {4{32'h12340000}},   18'h6666,  1'b1, {4{32'h12346666}},     1'b1); // iohl
    vecs[6]  = mk(3'd0, 11'b01101000000, {4{32'd1}},           {4{32'd2}},           {4{32'd1}},          18'h0,     1'b1, exp_addx,              EXT);  // addx
    vecs[7]  = mk(3'd0, 11'b01101000001, {4{32'd1}},           {4{32'd5}},           {4{32'd1}},          18'h0,     1'b1, exp_sfx,               EXT);  // sfx
    vecs[8]  = mk(3'd0, 11'b00011000010, {4{32'hFFFFFFFF}},    {4{32'd1}},           '0,                  18'h0,     1'b1, exp_cg,                EXT);  // cg
    vecs[9]  = mk(3'd0, 11'b00001000010, {4{32'd5}},           {4{32'd5}},           '0,                  18'h0,     1'b1, exp_bg,                EXT);  // bg
    vecs[10] = mk(3'd0, 11'd0,           {4{32'd7}},           {4{32'd7}},           '0,                  18'h0,     1'b1, '0,                    1'b0); // all-zero op
    vecs[11] = mk(3'd0, 11'b00011000000, {4{32'hFFFFFFFF}},    {4{32'd2}},           '0,                  18'h0,     1'b1, {4{32'd1}},            1'b1); // a wraps
    vecs[12] = mk(3'd0, 11'b00001000000, {4{32'd5}},           {4{32'd3}},           '0,                  18'h0,     1'b1, {4{32'hFFFFFFFE}},     1'b1); // sf
    vecs[13] = mk(3'd0, 11'b00011000001, {4{32'hF0F0F0F0}},    {4{32'hFF00FF00}},    '0,                  18'h0,     1'b1, {4{32'hF000F000}},     1'b1); // and
    vecs[14] = mk(3'd0, 11'b00011001001, {4{32'hF0F0F0F0}},    {4{32'hFF00FF00}},    '0,                  18'h0,     1'b1, {4{32'h0FFF0FFF}},     1'b1); // nand
    vecs[15] = mk(3'd0, 11'b01001000001, {4{32'hF0F0F0F0}},    {4{32'hFF00FF00}},    '0,                  18'h0,     1'b1, {4{32'h0FF00FF0}},     1'b1); // xor
    vecs[16] = mk(3'd0, 11'b00001000001, {4{32'hF0F0F0F0}},    {4{32'hFF00FF00}},    '0,                  18'h0,     1'b1, {4{32'hFFF0FFF0}},     1'b1); // or
    vecs[17] = mk(3'd0, 11'b01001000000, {4{32'hFFFFFFFF}},    {4{32'd1}},           '0,                  18'h0,     1'b1, '0,                    1'b1); // cgt -1>1
    vecs[18] = mk(3'd0, 11'b01011000000, {4{32'hFFFFFFFF}},    {4{32'd1}},           '0,                  18'h0,     1'b1, {128{1'b1}},           1'b1); // clgt
    vecs[19] = mk(3'd0, 11'b01111001000, {8{16'h1234}},        {8{16'h1234}},        '0,                  18'h0,     1'b1, {8{16'hFFFF}},         1'b1); // ceqh
    vecs[20] = mk(3'd4, 11'b01001101,    {8{16'h0001}},        '0,                   '0,                  18'h3FF,   1'b1, {8{16'hFFFF}},         1'b1); // cgthi 1>-1
    vecs[21] = mk(3'd5, 11'b010000001,   '0,                   '0,                   '0,                  18'h8000,  1'b1, {4{32'hFFFF8000}},     1'b1); // il
    vecs[22] = mk(3'd5, 11'b010000011,   '0,                   '0,                   '0,                  18'hABCD,  1'b1, {8{16'hABCD}},         1'b1); // ilh
    vecs[23] = mk(3'd4, 11'b00011100,    {4{32'd1000}},        '0,                   '0,                  18'h200,   1'b1, {4{32'd488}},          1'b1); // ai -512
    vecs[24] = mk(3'd4, 11'b01111100,    {4{32'd5}},           '0,                   '0,                  18'h005,   1'b1, {128{1'b1}},           1'b1); // ceqi
    vecs[25] = mk(3'd0, 11'b01011001000, {8{16'h8000}},        {8{16'h7FFF}},        '0,                  18'h0,     1'b1, {8{16'hFFFF}},         1'b1); // clgth
    vecs[26] = mk(3'd7, 11'b00011001000, {8{16'h0010}},        {8{16'h0001}},        '0,                  18'h0,     1'b1, '0,                    1'b0); // bad format
    vecs[27] = mk(3'd0, 11'b00011001000, {8{16'h0010}},        {8{16'h0001}},        '0,                  18'h0,     1'b0, {8{16'h0011}},         1'b0); // ah, no write
    vecs[28] = mk(3'd4, 11'b10011101,    {8{16'h0005}},        '0,                   '0,                  18'h001,   1'b1, '0,                    1'b0); // ahi + stray high bit
    vecs[29] = mk(3'd0, 11'b01011010000, {16{8'h01}},          {16{8'hFF}},          '0,                  18'h0,     1'b1, '0,                    1'b1); // clgtb 1>255 false

    nop();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset wb_data", wb_data, '0);
    check("reset wb_reg_addr", 128'(wb_reg_addr), '0);
    check("reset wb_en", 128'(wb_enable_reg_write), '0);
    check("reset delayed_rt", 128'(delayed_rt_addr), '0);
    check("reset delayed_en", 128'(delayed_enable_reg_write), '0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].fmt, vecs[i].op, 7'(i + 3), vecs[i].ra, vecs[i].rb, vecs[i].st,
            vecs[i].imm, vecs[i].en, 1'b0);
      @(posedge clock);
      #1;
      nop();
      check($sformatf("vec%0d delayed_rt", i), 128'(delayed_rt_addr), 128'(i + 3));
      check($sformatf("vec%0d delayed_en", i), 128'(delayed_enable_reg_write), 128'(vecs[i].exp_we));
      @(posedge clock);
      #1;
      check($sformatf("vec%0d wb_data", i), wb_data, vecs[i].exp_data);
      check($sformatf("vec%0d wb_reg_addr", i), 128'(wb_reg_addr), 128'(i + 3));
      check($sformatf("vec%0d wb_en", i), 128'(wb_enable_reg_write), 128'(vecs[i].exp_we));
    end

    // Taken branch squashes the write but the address still flows.
    drive(3'd0, 11'b00011001000, 7'd7, {8{16'h0010}}, {8{16'h0001}}, '0, '0, 1'b1, 1'b1);
    @(posedge clock);
    #1;
    nop();
    check("branch delayed_rt", 128'(delayed_rt_addr), 128'd7);
    check("branch delayed_en", 128'(delayed_enable_reg_write), '0);
    @(posedge clock);
    #1;
    check("branch wb_reg_addr", 128'(wb_reg_addr), 128'd7);
    check("branch wb_en", 128'(wb_enable_reg_write), '0);

    // Reset with two instructions in flight.
    drive(3'd0, 11'b00011001000, 7'd9, {8{16'h0010}}, {8{16'h0001}}, '0, '0, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    drive(3'd4, 11'b00011100, 7'd10, {4{32'd1}}, '0, '0, 18'h1, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("flush wb_data", wb_data, '0);
    check("flush wb_en", 128'(wb_enable_reg_write), '0);
    check("flush wb_reg_addr", 128'(wb_reg_addr), '0);
    check("flush delayed_rt", 128'(delayed_rt_addr), '0);
    check("flush delayed_en", 128'(delayed_enable_reg_write), '0);

    // Back-to-back ai instructions emerge in order, one per cycle.
    drive(3'd4, 11'b00011100, 7'd4, {4{32'd10}}, '0, '0, 18'h1, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    check("b2b first wb_en still 0", 128'(wb_enable_reg_write), '0);
    drive(3'd4, 11'b00011100, 7'd5, {4{32'd20}}, '0, '0, 18'h1, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    check("b2b0 wb_data", wb_data, {4{32'd11}});
    check("b2b0 wb_reg_addr", 128'(wb_reg_addr), 128'd4);
    check("b2b0 wb_en", 128'(wb_enable_reg_write), 128'd1);
    drive(3'd4, 11'b00011100, 7'd6, {4{32'd30}}, '0, '0, 18'h1, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    nop();
    check("b2b1 wb_data", wb_data, {4{32'd21}});
    check("b2b1 wb_reg_addr", 128'(wb_reg_addr), 128'd5);
    @(posedge clock);
    #1;
    check("b2b2 wb_data", wb_data, {4{32'd31}});
    check("b2b2 wb_reg_addr", 128'(wb_reg_addr), 128'd6);
    check("b2b2 wb_en", 128'(wb_enable_reg_write), 128'd1);
    @(posedge clock);
    #1;
    check("b2b drain wb_en", 128'(wb_enable_reg_write), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
